instr_fetch_issue: RTL and testbench
====================================

// Module: instr_fetch_issue
// PURPOSE
//  Instruction-side transmitter feeding the decoder's raw_instruction input. Walks a PC over
//  instruction memory from start_pc to end_pc, one 18-bit word per address, and issues each word
//  with a valid/ready handshake. Accepts PC redirects from the loop unit for JUMP_OR_END_LOOP.
//  Buffers fetched words so a 1-cycle-latency memory never stalls a ready consumer.
// PARAMETERS
//  PC_W       10  instruction address width
//  BUF_DEPTH  2   output buffer entries, power of 2, >=2
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high
//  start            in   1        pulse: begin program; ignored unless IDLE or DONE
//  start_pc         in   PC_W     first instruction address, sampled on start
//  end_pc           in   PC_W     last instruction address (inclusive), sampled on start
//  imem_en          out  1        memory read strobe
//  imem_addr        out  PC_W     memory read address
//  imem_rdata       in   [0:17]   read data, valid exactly 1 cycle after imem_en
//  raw_instruction  out  [0:17]   issued word, bits [0:4] = opcode, MSB first
//  instr_valid      out  1        raw_instruction valid
//  instr_ready      in   1        decoder accepts; transfer = valid & ready
//  redirect_valid   in   1        loop-unit jump request, 1-cycle pulse
//  redirect_pc      in   PC_W     jump target
//  busy             out  1        state is FETCH or DRAIN
//  done             out  1        1-cycle pulse when the last word has been transferred
// BEHAVIOUR
//  Reset: state IDLE; imem_en=0, imem_addr=0, raw_instruction=0, instr_valid=0, busy=0, done=0;
//   buffer emptied, in-flight read dropped.
//  States: IDLE -start-> FETCH; FETCH -(pc>end_pc)-> DRAIN; DRAIN -(buffer empty & nothing
//   in flight)-> DONE (done=1 for that cycle) -> IDLE. A start while in DONE goes to FETCH.
//  PC is PC_W+1 bits internally, so end_pc=2^PC_W-1 terminates without wrapping to 0.
//  Fetch credit: imem_en=1 only in FETCH when occupancy + in_flight < BUF_DEPTH, so the
//   buffer never overflows. pc increments on every imem_en.
//  Latency: start -> imem_en next cycle -> instr_valid two cycles after imem_en
//   (3 cycles start->first valid). With instr_ready held 1: one transfer per cycle.
//  Handshake: while instr_valid & !instr_ready, raw_instruction is held stable. instr_valid
//   never drops without a transfer, except on redirect or reset.
//  Redirect (FETCH or DRAIN): a transfer in the same cycle completes. All other buffered words
//   are flushed. The in-flight read is discarded via a 1-bit epoch tag. pc <= redirect_pc.
//   State returns to FETCH. First post-redirect word is valid 2 cycles after the redirect cycle.
//  Redirect in IDLE/DONE: ignored. start while busy: ignored. A redirect target > end_pc leads
//   straight to DRAIN and then DONE.
// CONFIGURATION
//  INSTR_FETCH_OPCODE_CHECK_EN defined: a buffered word with opcode >= 20 is not issued.
//   instr_valid stays 0, the unit flushes and enters DONE, and the extra output
//   illegal_opcode (1 bit, reset 0) pulses together with done.
//  Not defined: every word is issued unchanged and the illegal_opcode port does not exist.
// STRUCTURE
//  Shared package: INSTR_W=18, OPCODE_W=5, opcode constants OP_MATMUL=0..OP_ZERO=14,
//   OP_LOAD=15, OP_STORE=16, OP_START_INDEPENDENT_LOOP=17, OP_START_LOOP=18,
//   OP_JUMP_OR_END_LOOP=19, OP_LAST_LEGAL=19, and the fetch_state_t enum.
//  Sub-module instr_issue_fifo: BUF_DEPTH x 18 FIFO with flush, push, pop, occupancy;
//   the parent owns PC, state, credit and epoch logic.
// TESTING
//  1. start_pc=0, end_pc=3, ready=1, mem[i]=i<<13 -> opcodes 0,1,2,3 on 4 consecutive
//     cycles; done 1 cycle after last transfer.
//  2. Same program, ready low for cycles 4-9 -> word 1 held stable; no imem_en once 2 words
//     are buffered or in flight; order and count preserved.
//  3. start_pc=10, end_pc=20, redirect_pc=12 pulsed on the cycle word 14 transfers ->
//     next issued words 12,13,...; stale word 15 never appears.
//  4. start_pc=end_pc=1023 (PC_W=10) -> exactly one transfer, then done; no fetch from 0.
//  5. reset asserted mid-program with valid=1 -> next cycle valid=0, busy=0, buffer empty;
//     new start restarts cleanly.
//  6. (macro on) word at pc 2 has opcode 21 -> words 0,1 issued, illegal_opcode and done
//     pulse together, word 2 never valid.

Source files
------------

// File: rtl/instr_fetch_issue_pkg.sv
// Shared types and constants for the instruction fetch/issue slice.
// Opcode legality is only enforced when INSTR_FETCH_OPCODE_CHECK_EN is defined.
package instr_fetch_issue_pkg;

    localparam int INSTR_W  = 18;
    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_MATMUL                = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_ZERO                  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_LOAD                  = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_STORE                 = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_START_INDEPENDENT_LOOP = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_START_LOOP            = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_JUMP_OR_END_LOOP      = 5'd19;
    localparam logic [OPCODE_W-1:0] OP_LAST_LEGAL            = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    // Instruction words are numbered MSB-first, so the opcode is the leading slice.
    function automatic logic [OPCODE_W-1:0] opcodeOf(input logic [0:INSTR_W-1] word);
        return word[0:OPCODE_W-1];
    endfunction

endpackage

// File: rtl/instr_issue_fifo.sv
// Small power-of-two FIFO holding fetched words until the decoder takes them.
// Flush discards everything, including a push in the same cycle.
module instr_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [0:WIDTH-1] pushData_i,
    input  logic             pop_i,
    output logic [0:WIDTH-1] headData_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] occupancy_o
);

    logic [0:WIDTH-1] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset; the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem[wrPtr_q] <= pushData_i;
        end
    end

    assign headData_o  = mem[rdPtr_q];
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;

endmodule

// File: rtl/instr_fetch_issue.sv
// Walks a PC from start_pc to end_pc, fetches 18-bit words and issues them with valid/ready.
// Optional opcode check: define INSTR_FETCH_OPCODE_CHECK_EN (adds illegal_opcode output).
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic [PC_W-1:0]    end_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [0:INSTR_W-1] imem_rdata,
    output logic [0:INSTR_W-1] raw_instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               busy,
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
    output logic               done,
    output logic               illegal_opcode
`else
    output logic               done
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [PC_W:0]    pc_q, pc_d;
    logic [PC_W:0]    endPc_q, endPc_d;
    logic             epoch_q, epoch_d;
    logic             inflight_q;
    logic             inflightEpoch_q;

    logic [0:INSTR_W-1] headWord;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W-1:0]   occAfterPop;
    logic               fifoPush, fifoPop, fifoFlush;
    logic               busyState, illegalHead, abortTake, redirectTake;
    logic               creditOk, instrValidInt;
    logic [PC_W:0]      redirectTarget;

    instr_issue_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (fifoFlush),
        .push_i      (fifoPush),
        .pushData_i  (imem_rdata),
        .pop_i       (fifoPop),
        .headData_o  (headWord),
        .empty_o     (fifoEmpty),
        .occupancy_o (occupancy)
    );

    assign busyState = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

`ifdef INSTR_FETCH_OPCODE_CHECK_EN
    assign illegalHead = !fifoEmpty && (opcodeOf(headWord) > OP_LAST_LEGAL);
`else
    assign illegalHead = 1'b0;
`endif

    assign abortTake      = busyState && illegalHead;
    assign redirectTake   = busyState && redirect_valid && !abortTake;
    assign fifoFlush      = redirectTake || abortTake;
    assign instrValidInt  = !fifoEmpty && !illegalHead;
    assign fifoPop        = instrValidInt && instr_ready;
    assign fifoPush       = inflight_q && (inflightEpoch_q == epoch_q) && !fifoFlush;
    assign redirectTarget = {1'b0, redirect_pc};

    // Credit counts the slot freed by this cycle's pop so a ready consumer sees no bubbles.
    assign occAfterPop = occupancy - CNT_W'(fifoPop);
    assign creditOk    = (occAfterPop + CNT_W'(inflight_q)) < CNT_W'(BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH, ST_DRAIN: begin
                if (abortTake) begin
                    state_d = ST_DONE;
                end else if (redirectTake || (state_q == ST_FETCH)) begin
                    state_d = (pc_d > endPc_q) ? ST_DRAIN : ST_FETCH;
                end else if ((occAfterPop == '0) && !fifoPush) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = start ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A redirect fetches its target in the same cycle, so its first word is valid two cycles later.
    always_comb begin
        imem_en         = 1'b0;
        imem_addr       = pc_q[PC_W-1:0];
        if (redirectTake) begin
            imem_en   = (redirectTarget <= endPc_q);
            imem_addr = redirect_pc;
        end else begin
            imem_en = (state_q == ST_FETCH) && !abortTake && (pc_q <= endPc_q) && creditOk;
        end
        busy            = busyState;
        done            = (state_q == ST_DONE);
        instr_valid     = instrValidInt;
        raw_instruction = instrValidInt ? headWord : '0;
    end

    always_comb begin
        pc_d    = pc_q;
        endPc_d = endPc_q;
        epoch_d = epoch_q;
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            pc_d    = {1'b0, start_pc};
            endPc_d = {1'b0, end_pc};
        end else if (redirectTake) begin
            pc_d    = redirectTarget + (PC_W+1)'(imem_en);
            epoch_d = ~epoch_q;
        end else if (imem_en) begin
            pc_d = pc_q + 1'b1;
        end
        if (abortTake) begin
            epoch_d = ~epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= '0;
            endPc_q         <= '0;
            epoch_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflightEpoch_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            endPc_q         <= endPc_d;
            epoch_q         <= epoch_d;
            inflight_q      <= imem_en;
            inflightEpoch_q <= epoch_d;
        end
    end

`ifdef INSTR_FETCH_OPCODE_CHECK_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= abortTake;
        end
    end

    assign illegal_opcode = illegal_q;
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue; the illegal-opcode scenario builds only with
// INSTR_FETCH_OPCODE_CHECK_EN defined.
module tb_instr_fetch_issue;
    import instr_fetch_issue_pkg::*;

    localparam int PC_W = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [PC_W-1:0]    start_pc, end_pc, imem_addr, redirect_pc;
    logic               imem_en;
    logic [0:INSTR_W-1] imem_rdata, raw_instruction;
    logic               instr_valid, instr_ready, redirect_valid, busy, done;
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
    logic               illegal_opcode;
`endif

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    instr_fetch_issue #(.PC_W(PC_W), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_pc        (start_pc),
        .end_pc          (end_pc),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .raw_instruction (raw_instruction),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy),
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
        .done            (done),
        .illegal_opcode  (illegal_opcode)
`else
        .done            (done)
`endif
    );

    // 1-cycle-latency instruction memory model.
    logic [0:INSTR_W-1] mem [1024];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [0:INSTR_W-1] xferQ[$];
    int xferCycQ[$], enCycQ[$], enAddrQ[$], doneCycQ[$], illegalCycQ[$];
    int holdErr = 0;
    logic prevStall = 1'b0;
    logic [0:INSTR_W-1] prevRaw = '0;

    // Logs transfers, fetches and done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            xferQ.push_back(raw_instruction);
            xferCycQ.push_back(cyc);
        end
        if (imem_en) begin
            enCycQ.push_back(cyc);
            enAddrQ.push_back(int'(imem_addr));
        end
        if (done) doneCycQ.push_back(cyc);
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
        if (illegal_opcode) illegalCycQ.push_back(cyc);
`endif
        if (prevStall && (!instr_valid || raw_instruction !== prevRaw)) holdErr++;
        prevStall = instr_valid && !instr_ready;
        prevRaw = raw_instruction;
    end

    function automatic logic [0:INSTR_W-1] expWord(input int a);
        logic [OPCODE_W-1:0] op;
        logic [INSTR_W-OPCODE_W-1:0] lo;
        op = OPCODE_W'(a % 20);
        lo = (INSTR_W-OPCODE_W)'(a);
        return {op, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        xferQ.delete(); xferCycQ.delete(); enCycQ.delete(); enAddrQ.delete();
        doneCycQ.delete(); illegalCycQ.delete();
        holdErr = 0;
    endtask

    // Runs one program: start at rel 0, ready low over [stallLo,stallHi], optional redirect pulse.
    task automatic applyStimulus(input int sPc, input int ePc, input int stallLo, input int stallHi,
                                 input int redirRel, input int redirPc, input int budget,
                                 output int startCyc, output bit timedOut);
        start_pc = PC_W'(sPc);
        end_pc = PC_W'(ePc);
        redirect_pc = PC_W'(redirPc);
        startCyc = cyc;
        timedOut = 1'b1;
        for (int rel = 0; rel < budget; rel++) begin
            start = (rel == 0);
            instr_ready = !(rel >= stallLo && rel <= stallHi);
            redirect_valid = (rel == redirRel);
            tick();
            if (doneCycQ.size() > 0) begin
                timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
        start_pc = '0; end_pc = '0; redirect_pc = '0; imem_rdata = '0;
        tick(); tick();
        @(negedge clk);
        checkCount++; if (imem_en !== 1'b0) $display("[TB] FAIL reset_imem_en: got %b want 0", imem_en); else passCount++;
        checkCount++; if (imem_addr !== '0) $display("[TB] FAIL reset_imem_addr: got %0d want 0", imem_addr); else passCount++;
        checkCount++; if (raw_instruction !== '0) $display("[TB] FAIL reset_raw: got %h want 0", raw_instruction); else passCount++;
        checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passCount++;
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
        checkCount++; if (illegal_opcode !== 1'b0) $display("[TB] FAIL reset_illegal: got %b want 0", illegal_opcode); else passCount++;
`endif
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_stream();
        int s; bit to;
        clearLog();
        applyStimulus(0, 3, -1, -2, -1, 0, 40, s, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL basic_timeout: done not seen in 40 cycles"); else passCount++;
        checkCount++; if (xferQ.size() != 4) $display("[TB] FAIL basic_count: got %0d want 4", xferQ.size()); else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (i >= xferQ.size() || xferQ[i] !== expWord(i) || xferCycQ[i] != s + 3 + i)
                $display("[TB] FAIL basic_word%0d: got %h at rel %0d want %h at rel %0d", i,
                         (i < xferQ.size()) ? xferQ[i] : '0, (i < xferCycQ.size()) ? xferCycQ[i] - s : -1,
                         expWord(i), 3 + i);
            else passCount++;
        end
        checkCount++; if (enCycQ.size() != 4 || enCycQ[0] != s + 1) $display("[TB] FAIL basic_fetch: got %0d fetches first at rel %0d want 4 first at rel 1", enCycQ.size(), (enCycQ.size() > 0) ? enCycQ[0] - s : -1); else passCount++;
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 7) $display("[TB] FAIL basic_done: got rel %0d want rel 7", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
    endtask

    task automatic test_backpressure();
        int s; bit to; int stallFetches;
        clearLog();
        applyStimulus(0, 3, 4, 9, -1, 0, 60, s, to);
        stallFetches = 0;
        foreach (enCycQ[i]) if (enCycQ[i] >= s + 4 && enCycQ[i] <= s + 9) stallFetches++;
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL bp_timeout: done not seen in 60 cycles"); else passCount++;
        checkCount++; if (holdErr != 0) $display("[TB] FAIL bp_hold: got %0d unstable stall cycles want 0", holdErr); else passCount++;
        checkCount++; if (stallFetches != 0) $display("[TB] FAIL bp_credit: got %0d fetches while full want 0", stallFetches); else passCount++;
        checkCount++; if (xferQ.size() != 4) $display("[TB] FAIL bp_count: got %0d want 4", xferQ.size()); else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (i >= xferQ.size() || xferQ[i] !== expWord(i))
                $display("[TB] FAIL bp_word%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : '0, expWord(i));
            else passCount++;
        end
        checkCount++; if (xferCycQ.size() < 2 || xferCycQ[1] != s + 10) $display("[TB] FAIL bp_release: got rel %0d want rel 10", (xferCycQ.size() > 1) ? xferCycQ[1] - s : -1); else passCount++;
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 13) $display("[TB] FAIL bp_done: got rel %0d want rel 13", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
    endtask

    task automatic test_redirect();
        int s; bit to;
        int expSeq[14] = '{10, 11, 12, 13, 14, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        clearLog();
        applyStimulus(10, 20, -1, -2, 7, 12, 80, s, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL redir_timeout: done not seen in 80 cycles"); else passCount++;
        checkCount++; if (xferQ.size() != 14) $display("[TB] FAIL redir_count: got %0d want 14", xferQ.size()); else passCount++;
        for (int i = 0; i < 14; i++) begin
            checkCount++;
            if (i >= xferQ.size() || xferQ[i] !== expWord(expSeq[i]))
                $display("[TB] FAIL redir_word%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : '0, expWord(expSeq[i]));
            else passCount++;
        end
        checkCount++; if (xferCycQ.size() < 6 || xferCycQ[5] != s + 9) $display("[TB] FAIL redir_latency: got rel %0d want rel 9", (xferCycQ.size() > 5) ? xferCycQ[5] - s : -1); else passCount++;
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 18) $display("[TB] FAIL redir_done: got rel %0d want rel 18", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
    endtask

    task automatic test_end_of_space();
        int s; bit to;
        clearLog();
        applyStimulus(1023, 1023, -1, -2, -1, 0, 40, s, to);
        tick(); tick(); tick();
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL eos_timeout: done not seen in 40 cycles"); else passCount++;
        checkCount++; if (xferQ.size() != 1 || xferQ[0] !== expWord(1023)) $display("[TB] FAIL eos_word: got %0d words first %h want 1 word %h", xferQ.size(), (xferQ.size() > 0) ? xferQ[0] : '0, expWord(1023)); else passCount++;
        checkCount++; if (enAddrQ.size() != 1 || enAddrQ[0] != 1023) $display("[TB] FAIL eos_fetch: got %0d fetches first addr %0d want 1 at 1023", enAddrQ.size(), (enAddrQ.size() > 0) ? enAddrQ[0] : -1); else passCount++;
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 4) $display("[TB] FAIL eos_done: got rel %0d want rel 4", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
    endtask

    task automatic test_reset_mid_program();
        int s; bit to;
        clearLog();
        start_pc = 10'd0; end_pc = 10'd30; instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        checkCount++; if (instr_valid !== 1'b1) $display("[TB] FAIL midrst_pre_valid: got %b want 1", instr_valid); else passCount++;
        tick();
        @(negedge clk);
        checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b want 0", instr_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (imem_en !== 1'b0) $display("[TB] FAIL midrst_imem_en: got %b want 0", imem_en); else passCount++;
        tick();
        reset = 1'b0;
        tick();
        clearLog();
        applyStimulus(0, 3, -1, -2, -1, 0, 40, s, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL midrst_timeout: done not seen in 40 cycles"); else passCount++;
        checkCount++; if (xferQ.size() != 4) $display("[TB] FAIL midrst_count: got %0d want 4", xferQ.size()); else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (i >= xferQ.size() || xferQ[i] !== expWord(i))
                $display("[TB] FAIL midrst_word%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : '0, expWord(i));
            else passCount++;
        end
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 7) $display("[TB] FAIL midrst_done: got rel %0d want rel 7", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
    endtask

`ifdef INSTR_FETCH_OPCODE_CHECK_EN
    task automatic test_illegal_opcode();
        int s; bit to;
        logic [OPCODE_W-1:0] badOp;
        logic [INSTR_W-OPCODE_W-1:0] badLo;
        badOp = 5'd21;
        badLo = '0;
        badLo[1] = 1'b1;
        mem[2] = {badOp, badLo};
        clearLog();
        applyStimulus(0, 5, -1, -2, -1, 0, 40, s, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL illegal_timeout: done not seen in 40 cycles"); else passCount++;
        checkCount++; if (xferQ.size() != 2) $display("[TB] FAIL illegal_count: got %0d want 2", xferQ.size()); else passCount++;
        for (int i = 0; i < 2; i++) begin
            checkCount++;
            if (i >= xferQ.size() || xferQ[i] !== expWord(i))
                $display("[TB] FAIL illegal_word%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : '0, expWord(i));
            else passCount++;
        end
        checkCount++; if (doneCycQ.size() != 1 || doneCycQ[0] != s + 6) $display("[TB] FAIL illegal_done: got rel %0d want rel 6", (doneCycQ.size() > 0) ? doneCycQ[0] - s : -1); else passCount++;
        checkCount++; if (illegalCycQ.size() != 1 || doneCycQ.size() != 1 || illegalCycQ[0] != doneCycQ[0]) $display("[TB] FAIL illegal_pulse: got %0d pulses at rel %0d want 1 at rel 6", illegalCycQ.size(), (illegalCycQ.size() > 0) ? illegalCycQ[0] - s : -1); else passCount++;
        mem[2] = expWord(2);
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = expWord(i);
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_redirect();
        test_end_of_space();
        test_reset_mid_program();
`ifdef INSTR_FETCH_OPCODE_CHECK_EN
        test_illegal_opcode();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
